// File: rtl/spi_master_core.sv
// Single-byte SPI master, mode 0, full duplex; MSB first by default.
// Optional SPI_MASTER_LSB_FIRST_EN: shift LSB first on both directions.
// Ports: clk, reset (sync, active high), start, tx_data[7:0] in;
//   rx_data[7:0], tx_ready, done, sclk, mosi out; miso in.
module spi_master_core #(
  parameter int SCLK_HALF = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       tx_ready,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int CW =
    (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CW-1:0] HALF_MAX =
    CW'(SCLK_HALF - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] half_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    sh_out;
  logic [7:0]    sh_in;
  logic          half_end;
  logic          out_bit;

  assign half_end = (half_cnt == HALF_MAX);

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign out_bit = sh_out[0];
`else
  assign out_bit = sh_out[7];
`endif

  always_comb begin
    state_nx = state;
    tx_ready = 1'b0;
    done     = 1'b0;
    sclk     = 1'b0;
    mosi     = 1'b0;
    unique case (state)
      IDLE: begin
        tx_ready = 1'b1;
        if (start) state_nx = LOW;
      end
      LOW: begin
        mosi = out_bit;
        if (half_end) state_nx = HIGH;
      end
      HIGH: begin
        sclk = 1'b1;
        mosi = out_bit;
        if (half_end)
          state_nx = (bit_cnt == 3'd7) ? DONE : LOW;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      sh_out   <= '0;
      sh_in    <= '0;
      rx_data  <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          half_cnt <= '0;
          if (start) begin
            sh_out  <= tx_data;
            bit_cnt <= '0;
          end
        end
        LOW: begin
          half_cnt <= half_end ? '0 : half_cnt + 1'b1;
          // sclk rising edge: capture miso
          if (half_end) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
            sh_in <= {miso, sh_in[7:1]};
`else
            sh_in <= {sh_in[6:0], miso};
`endif
          end
        end
        HIGH: begin
          half_cnt <= half_end ? '0 : half_cnt + 1'b1;
          if (half_end) begin
            if (bit_cnt == 3'd7) begin
              // visible while done is high
              rx_data <= sh_in;
            end else begin
`ifdef SPI_MASTER_LSB_FIRST_EN
              sh_out <= {1'b0, sh_out[7:1]};
`else
              sh_out <= {sh_out[6:0], 1'b0};
`endif
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        DONE: half_cnt <= '0;
        default: half_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_core.sv
// Randomized self-checking bench for spi_master_core.
// Loopback and external-miso transfers checked against a byte-level model.
module tb_spi_master_core;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       done;
  logic       sclk;
  logic       mosi;
  logic       miso;

  logic       loop;
  logic [7:0] ext_byte;
  int         ext_idx;
  int         rises;
  int         viol;
  logic       prev_sclk;
  logic       mq[$];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_master_core #(.SCLK_HALF(H)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .tx_ready (tx_ready),
    .done     (done),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso)
  );

  // i-th bit on the wire for byte b
  function automatic logic bit_of(
    input logic [7:0] b, input int i);
    if (i < 0 || i > 7) return 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
    return b[i];
`else
    return b[7-i];
`endif
  endfunction

  assign miso = loop ? mosi : bit_of(ext_byte, ext_idx);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // sclk edge monitor, ext miso driver
  always @(negedge clk) begin
    if (sclk && !prev_sclk) begin
      rises++;
      mq.push_back(mosi);
    end
    if (!sclk && prev_sclk) ext_idx++;
    if (tx_ready && sclk) viol++;
    prev_sclk = sclk;
  end

  task automatic xfer(input logic [7:0] tx,
                      input logic lp,
                      input logic [7:0] ext,
                      input bit poke);
    int k;
    int n;
    bit got;
    logic [7:0] gb;
    logic [7:0] eb;
    k = 0;
    while (!tx_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!tx_ready) begin
      check("idle_timeout", 0, 1);
      return;
    end
    loop     = lp;
    ext_byte = ext;
    ext_idx  = 0;
    rises    = 0;
    mq.delete();
    start    = 1'b1;
    tx_data  = tx;
    @(posedge clk);
    #1;
    start   = 1'b0;
    tx_data = 8'($urandom);
    n   = 0;
    got = 0;
    while (n < 400 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) check("mosi_first", mosi, bit_of(tx, 0));
      if (poke && n == 20) begin
        check("busy", tx_ready, 0);
        start   = 1'b1;
        tx_data = ~tx;
      end else begin
        start = 1'b0;
      end
      if (done) got = 1;
    end
    if (!got) begin
      check("done_timeout", 0, 1);
      return;
    end
    check("latency", n, 16 * H + 1);
    check("rx", rx_data, lp ? tx : ext);
    check("rises", rises, 8);
    gb = '0;
    eb = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < mq.size()) gb[i] = mq[i];
      eb[i] = bit_of(tx, i);
    end
    check("mosi_bits", gb, eb);
    @(negedge clk);
    check("done_width", done, 0);
    check("ready_after", tx_ready, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int dn;
    reset     = 1'b1;
    start     = 1'b0;
    tx_data   = '0;
    loop      = 1'b1;
    ext_byte  = '0;
    ext_idx   = 0;
    rises     = 0;
    viol      = 0;
    prev_sclk = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("rst_ready", tx_ready, 1);
    check("rst_done", done, 0);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_rx", rx_data, 0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // back-to-back loopback
    xfer(8'hF0, 1, 8'h00, 0);
    xfer(8'h0F, 1, 8'h00, 0);
    xfer(8'hAA, 1, 8'h00, 0);
    xfer(8'h55, 1, 8'h00, 0);
`ifdef SPI_MASTER_LSB_FIRST_EN
    xfer(8'h01, 1, 8'h00, 0);
`endif
    // external miso
    xfer(8'hA5, 0, 8'h3C, 0);
    // start during transfer is ignored
    xfer(8'h96, 1, 8'h00, 1);

    // reset during bit 4
    xfer(8'h5A, 1, 8'h00, 0);
    loop    = 1'b1;
    rises   = 0;
    start   = 1'b1;
    tx_data = 8'hC3;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (!(rises == 4 && !sclk) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reach_bit4", rises, 4);
    reset = 1'b1;
    @(negedge clk);
    check("arst_sclk", sclk, 0);
    check("arst_ready", tx_ready, 1);
    check("arst_rx", rx_data, 0);
    check("arst_done", done, 0);
    check("arst_mosi", mosi, 0);
    reset = 1'b0;
    dn = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("no_done", dn, 0);
    xfer(8'h81, 1, 8'h00, 0);

    // random traffic
    for (int i = 0; i < 20; i++) begin
      xfer(8'($urandom), 1'($urandom),
           8'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    check("sclk_idle_low", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
